// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding,
// inMEM control bit positions and the default access timeout.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int MEM_READ  = 2;
    localparam int BRANCH    = 1;
    localparam int MEM_WRITE = 0;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WAIT_W          = 8;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: runs one request per held op, waits for the
// acknowledge with a bounded counter, buffers load data and keeps the sticky
// misalign/timeout flags. All state changes on the falling clock edge.
module dmem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mem_ctl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        drop,
    output logic [31:0] load_data,
    output logic        misalign_flag,
    output logic        timeout_flag
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [31:0]         rbuf;
    logic                timed_out;
    logic                op;
    logic                is_load;
    logic                misaligned;
    logic                hit_timeout;

    // A write bit beats a read bit when both are set.
    assign op          = mem_ctl[MEM_READ] | mem_ctl[MEM_WRITE];
    assign is_load     = mem_ctl[MEM_READ] & ~mem_ctl[MEM_WRITE];
    assign misaligned  = op & (addr[1:0] != 2'b00);
    assign hit_timeout = (wait_cnt == TIMEOUT_CNT);

    assign stall     = op & (state != ST_DONE) & ~misaligned;
    // The op is retired as a bubble when misaligned or when its access timed out.
    assign drop      = misaligned | ((state == ST_DONE) & timed_out);
    assign load_data = ((state == ST_DONE) && is_load && !timed_out) ? rbuf : 32'd0;

    // State register.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and memory port drive; ack wins over timeout.
    always_comb begin
        next_state = state;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        case (state)
            ST_IDLE: begin
                if (op && !misaligned) next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = mem_ctl[MEM_WRITE];
                dmem_addr  = addr;
                dmem_wdata = wdata;
                if (dmem_ack || hit_timeout) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Wait counter, load buffer, per-access timeout marker and sticky flags.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt      <= '0;
            rbuf          <= 32'd0;
            timed_out     <= 1'b0;
            misalign_flag <= 1'b0;
            timeout_flag  <= 1'b0;
        end else begin
            if (misaligned) misalign_flag <= 1'b1;
            if (state == ST_IDLE) begin
                if (op && !misaligned) begin
                    wait_cnt  <= '0;
                    timed_out <= 1'b0;
                end
            end else if (state == ST_ACCESS) begin
                if (dmem_ack) begin
                    if (is_load) rbuf <= dmem_rdata;
                end else if (hit_timeout) begin
                    timed_out    <= 1'b1;
                    timeout_flag <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: branch resolution, data-memory access through
// dmem_access_fsm, and the MEM/WB pipeline register (falling-edge clocked).
module memory_access
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  inWB,
    input  logic [2:0]  inMEM,
    input  logic [31:0] inPCJump,
    input  logic [31:0] inALUResult,
    input  logic        inALUZero,
    input  logic [31:0] inRegB,
    input  logic [4:0]  inRegF_wreg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [1:0]  outWB,
    output logic [4:0]  outRegF_wreg,
    output logic [31:0] outReadData,
    output logic [31:0] outALUResult,
    output logic        outPCSrc,
    output logic [31:0] outPCJump,
    output logic        outStall,
    output logic        outMisalign,
    output logic        outTimeout
);

    logic        stall;
    logic        drop;
    logic [31:0] load_data;

    // Branch decision is purely combinational and ignores the access FSM.
    assign outPCSrc  = inMEM[BRANCH] & inALUZero;
    assign outPCJump = inPCJump;
    assign outStall  = stall;

    dmem_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .mem_ctl       (inMEM),
        .addr          (inALUResult),
        .wdata         (inRegB),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .drop          (drop),
        .load_data     (load_data),
        .misalign_flag (outMisalign),
        .timeout_flag  (outTimeout)
    );

    // MEM/WB register: bubble while stalled, otherwise retire the held op.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            outWB        <= 2'b00;
            outReadData  <= 32'd0;
            outALUResult <= 32'd0;
            outRegF_wreg <= 5'd0;
        end else if (stall) begin
            outWB <= 2'b00;
        end else begin
            outWB        <= drop ? 2'b00 : inWB;
            outALUResult <= inALUResult;
            outRegF_wreg <= inRegF_wreg;
            outReadData  <= load_data;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Randomized scoreboard bench for memory_access: a stimulus process issues ops
// and queues the expected MEM/WB result, a memory responder acks requests
// after a chosen delay, and a monitor compares every retired op and bubble.
module tb_memory_access;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  inWB;
    logic [2:0]  inMEM;
    logic [31:0] inPCJump;
    logic [31:0] inALUResult;
    logic        inALUZero;
    logic [31:0] inRegB;
    logic [4:0]  inRegF_wreg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ack;
    logic [1:0]  outWB;
    logic [4:0]  outRegF_wreg;
    logic [31:0] outReadData;
    logic [31:0] outALUResult;
    logic        outPCSrc;
    logic [31:0] outPCJump;
    logic        outStall;
    logic        outMisalign;
    logic        outTimeout;

    logic resp_ack = 1'b0;
    logic man_ack  = 1'b0;
    assign dmem_ack = resp_ack | man_ack;

    memory_access #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .inWB         (inWB),
        .inMEM        (inMEM),
        .inPCJump     (inPCJump),
        .inALUResult  (inALUResult),
        .inALUZero    (inALUZero),
        .inRegB       (inRegB),
        .inRegF_wreg  (inRegF_wreg),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .outWB        (outWB),
        .outRegF_wreg (outRegF_wreg),
        .outReadData  (outReadData),
        .outALUResult (outALUResult),
        .outPCSrc     (outPCSrc),
        .outPCJump    (outPCJump),
        .outStall     (outStall),
        .outMisalign  (outMisalign),
        .outTimeout   (outTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [31:0] rd;
        bit          full;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference memory (what the program expects) and the responder's memory.
    logic [31:0] mdl [logic [31:0]];
    logic [31:0] ram [logic [31:0]];

    // Expectations shared with the responder for the op currently held.
    bit          exp_req_ok  = 1'b0;
    logic [31:0] exp_addr    = 32'd0;
    logic        exp_we      = 1'b0;
    logic [31:0] exp_wdata   = 32'd0;
    int          ack_delay   = 0;
    bit          resp_no_ack = 1'b0;
    bit          exp_mis     = 1'b0;
    bit          exp_to      = 1'b0;
    bit          mon_en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] seed_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : seed_val(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : seed_val(a);
    endfunction

    // Memory responder: acks each request after ack_delay cycles.
    initial begin
        int cnt;
        bit acked;
        cnt   = 0;
        acked = 1'b0;
        forever begin
            @(posedge clk);
            dmem_rdata = $urandom;
            if (acked) begin
                chk("req_single_cycle", 32'(dmem_req), 32'd0);
                acked = 1'b0;
            end
            if (!rst) begin
                resp_ack = 1'b0;
                cnt      = 0;
            end else if (dmem_req) begin
                if (cnt == 0) begin
                    chk("req_allowed", 32'(dmem_req), 32'(exp_req_ok));
                    chk("dmem_addr", dmem_addr, exp_addr);
                    chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                    if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
                end
                if (!resp_no_ack && cnt == ack_delay) begin
                    resp_ack = 1'b1;
                    acked    = 1'b1;
                    if (dmem_we) ram[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = ram_rd(dmem_addr);
                end else begin
                    resp_ack = 1'b0;
                end
                cnt++;
            end else begin
                resp_ack = 1'b0;
                cnt      = 0;
            end
        end
    end

    // Monitor: each falling edge either retires the head of the queue or
    // loads a bubble, depending on the stall seen just before that edge.
    initial begin
        bit   prev_stall;
        bit   prev_valid;
        exp_t e;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            if (mon_en && prev_valid) begin
                if (!prev_stall) begin
                    if (q.size() == 0) begin
                        chk("unexpected_retire", 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        chk("outWB", 32'(outWB), 32'(e.wb));
                        if (e.full) begin
                            chk("outALUResult", outALUResult, e.alu);
                            chk("outRegF_wreg", 32'(outRegF_wreg), 32'(e.wreg));
                            chk("outReadData", outReadData, e.rd);
                        end
                    end
                end else begin
                    chk("bubble_outWB", 32'(outWB), 32'd0);
                end
            end
            prev_stall = outStall;
            prev_valid = mon_en && rst;
        end
    end

    // Issue one op; must be called just after a falling edge. Returns just
    // after the edge that retires it.
    task automatic do_op(input logic [2:0] mem, input logic [1:0] wb, input logic [31:0] addr,
                         input logic [31:0] regb, input logic [4:0] wreg, input logic zero,
                         input logic [31:0] pcj, input int delay, input bit noack);
        exp_t e;
        bit   op;
        bit   mis;
        int   n;
        int   es;
        op  = mem[2] | mem[0];
        mis = op && (addr[1:0] != 2'b00);
        inMEM       = mem;
        inWB        = wb;
        inALUResult = addr;
        inRegB      = regb;
        inRegF_wreg = wreg;
        inALUZero   = zero;
        inPCJump    = pcj;
        ack_delay   = delay;
        resp_no_ack = noack;
        exp_req_ok  = op && !mis;
        exp_addr    = addr;
        exp_we      = mem[0];
        exp_wdata   = regb;
        e.wb   = (mis || (op && noack)) ? 2'b00 : wb;
        e.alu  = addr;
        e.wreg = wreg;
        e.rd   = (op && !mis && !mem[0] && !noack) ? mdl_rd(addr) : 32'd0;
        e.full = !mis;
        if (op && !mis && mem[0] && !noack) mdl[addr] = regb;
        q.push_back(e);
        if (mis) exp_mis = 1'b1;
        if (op && !mis && noack) exp_to = 1'b1;
        es = !(op && !mis) ? 0 : (noack ? TO + 2 : delay + 2);
        #1;
        chk("outPCSrc", 32'(outPCSrc), 32'(mem[1] & zero));
        chk("outPCJump", outPCJump, pcj);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            if (!outStall) break;
            n++;
        end
        chk("stall_cycles", 32'(n), 32'(es));
        @(negedge clk);
        #1;
        chk("outMisalign", 32'(outMisalign), 32'(exp_mis));
        chk("outTimeout", 32'(outTimeout), 32'(exp_to));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        inWB        = 2'b00;
        inMEM       = 3'b000;
        inPCJump    = 32'd0;
        inALUResult = 32'd0;
        inALUZero   = 1'b0;
        inRegB      = 32'd0;
        inRegF_wreg = 5'd0;
        mdl[32'h40] = 32'hDEADBEEF;
        ram[32'h40] = 32'hDEADBEEF;
        #2;
        chk("rst_outWB", 32'(outWB), 32'd0);
        chk("rst_outReadData", outReadData, 32'd0);
        chk("rst_outALUResult", outALUResult, 32'd0);
        chk("rst_outRegF_wreg", 32'(outRegF_wreg), 32'd0);
        chk("rst_outMisalign", 32'(outMisalign), 32'd0);
        chk("rst_outTimeout", 32'(outTimeout), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        mon_en = 1'b1;

        // Pass-through, load with 3 wait cycles, store with immediate ack.
        do_op(3'b000, 2'b10, 32'h1234, 32'h0, 5'd5, 1'b0, 32'h0, 0, 1'b0);
        do_op(3'b100, 2'b11, 32'h40, 32'h0, 5'd7, 1'b0, 32'h0, 3, 1'b0);
        do_op(3'b001, 2'b00, 32'h10, 32'hA5A5A5A5, 5'd0, 1'b0, 32'h0, 0, 1'b0);
        do_op(3'b100, 2'b01, 32'h10, 32'h0, 5'd9, 1'b0, 32'h0, 1, 1'b0);
        // Branch taken / not taken.
        do_op(3'b010, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 32'h80, 0, 1'b0);
        do_op(3'b010, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h80, 0, 1'b0);
        // Misaligned load, then a load that is never acknowledged.
        do_op(3'b100, 2'b11, 32'h42, 32'h0, 5'd3, 1'b0, 32'h0, 0, 1'b0);
        do_op(3'b100, 2'b11, 32'h50, 32'h0, 5'd4, 1'b0, 32'h0, 0, 1'b1);
        // Both read and write set: behaves as a store.
        do_op(3'b101, 2'b10, 32'h44, 32'h12345678, 5'd6, 1'b0, 32'h0, 2, 1'b0);
        do_op(3'b100, 2'b10, 32'h44, 32'h0, 5'd6, 1'b0, 32'h0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), a, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 6), 1'b0);
        end

        // Reset during an access: request drops at once, late ack ignored.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        @(negedge clk);
        #1;
        q.delete();
        inMEM       = 3'b100;
        inWB        = 2'b11;
        inALUResult = 32'h20;
        inRegF_wreg = 5'd12;
        resp_no_ack = 1'b1;
        exp_req_ok  = 1'b1;
        exp_addr    = 32'h20;
        exp_we      = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (dmem_req) break;
        end
        chk("reset_test_req_seen", 32'(dmem_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
        chk("midrst_outWB", 32'(outWB), 32'd0);
        chk("midrst_outReadData", outReadData, 32'd0);
        chk("midrst_outALUResult", outALUResult, 32'd0);
        chk("midrst_outRegF_wreg", 32'(outRegF_wreg), 32'd0);
        chk("midrst_outMisalign", 32'(outMisalign), 32'd0);
        chk("midrst_outTimeout", 32'(outTimeout), 32'd0);
        exp_mis     = 1'b0;
        exp_to      = 1'b0;
        inMEM       = 3'b000;
        inWB        = 2'b00;
        exp_req_ok  = 1'b0;
        @(negedge clk);
        #1;
        rst     = 1'b1;
        man_ack = 1'b1;
        @(negedge clk);
        #1;
        man_ack = 1'b0;
        chk("late_ack_dmem_req", 32'(dmem_req), 32'd0);
        chk("late_ack_outStall", 32'(outStall), 32'd0);
        chk("late_ack_outReadData", outReadData, 32'd0);
        chk("late_ack_outTimeout", 32'(outTimeout), 32'd0);
        mon_en = 1'b1;

        do_op(3'b000, 2'b01, 32'h777, 32'h0, 5'd1, 1'b0, 32'h4, 0, 1'b0);
        do_op(3'b100, 2'b11, 32'h40, 32'h0, 5'd2, 1'b0, 32'h8, 2, 1'b0);

        @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for dmem_ack before aborting an access.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port `inWB`, input, 2 bits: write-back control from EX/MEM.
REQ-005 SHALL have port `inMEM`, input, 3 bits: [2]=MemRead, [1]=Branch, [0]=MemWrite.
REQ-006 SHALL have port `inPCJump`, input, 32 bits: branch target.
REQ-007 SHALL have port `inALUResult`, input, 32 bits: data address, or pass-through result.
REQ-008 SHALL have port `inALUZero`, input, 1 bit: ALU zero flag.
REQ-009 SHALL have port `inRegB`, input, 32 bits: store data.
REQ-010 SHALL have port `inRegF_wreg`, input, 5 bits: destination register.
REQ-011 SHALL have port `dmem_req`, output, 1 bit: data-memory request.
REQ-012 SHALL have port `dmem_we`, output, 1 bit: data-memory write enable.
REQ-013 SHALL have ports `dmem_addr` and `dmem_wdata`, output, 32 bits each: address and store data.
REQ-014 SHALL have ports `dmem_rdata` (input, 32 bits) and `dmem_ack` (input, 1 bit): load data, access complete.
REQ-015 SHALL have ports `outWB` (output, 2 bits) and `outRegF_wreg` (output, 5 bits): MEM/WB control and destination.
REQ-016 SHALL have ports `outReadData` and `outALUResult`, output, 32 bits each: MEM/WB load data and result.
REQ-017 SHALL have ports `outPCSrc` (output, 1 bit) and `outPCJump` (output, 32 bits): branch-taken select and target.
REQ-018 SHALL have port `outStall`, output, 1 bit: upstream hold request.
REQ-019 SHALL have ports `outMisalign` and `outTimeout`, output, 1 bit each: sticky error flags.

Function
REQ-020 SHALL drive outPCSrc = inMEM[1] & inALUZero and outPCJump = inPCJump combinationally, independent of FSM state.
REQ-021 SHALL treat a memory op as present when inMEM[2]|inMEM[0]; if both bits are set, write wins.
REQ-022 SHALL implement FSM IDLE, ACCESS, DONE.
- IDLE + op + aligned address -> ACCESS.
- ACCESS + dmem_ack -> DONE.
- ACCESS + counter==TIMEOUT -> DONE.
- DONE -> IDLE.
REQ-023 SHALL assert dmem_req only in ACCESS, with dmem_addr=inALUResult, dmem_wdata=inRegB, dmem_we=inMEM[0]; dmem_req is 0 and the other memory outputs are 0 elsewhere.
REQ-024 SHALL capture dmem_rdata into an internal buffer on the edge where ACCESS sees dmem_ack with a read op.
REQ-025 SHALL drive outStall = op present & state!=DONE & !misaligned, combinationally; upstream holds its inputs while outStall=1.
REQ-026 SHALL load the MEM/WB register on every falling edge.
- outStall=0: load inWB, inALUResult, inRegF_wreg, and read buffer (0 for non-loads).
- outStall=1: load a bubble (outWB=00, other fields unchanged).
REQ-027 SHALL treat inALUResult[1:0]!=0 with an op as misaligned.
- No request issued; outStall=0.
- outMisalign set.
- The op passes as a bubble (outWB=00).
REQ-028 SHALL use an 8-bit wait counter: cleared on entering ACCESS, incremented each ACCESS cycle without ack.
- Timeout sets outTimeout and loads outReadData=0.
- On timeout, outWB is forced to 00.
REQ-029 SHALL give ack priority over timeout when both occur on the same edge.
REQ-030 SHALL ignore dmem_ack outside ACCESS.
REQ-031 SHALL have a load or store latency through the stage of ack cycle + 1 (DONE); a non-memory op's latency SHALL be 1 edge.

Reset
REQ-032 SHALL, while rst=0, force:
- state=IDLE; counter=0; read buffer=0.
- outWB=00; outReadData=0; outALUResult=0; outRegF_wreg=0.
- outMisalign=0; outTimeout=0.
- dmem_req=0.
REQ-033 SHALL, on reset asserted mid-ACCESS, drop dmem_req immediately and discard the access; a late ack SHALL be ignored.
REQ-034 SHALL clear the sticky flags only by reset.

Structure
REQ-035 SHALL place the following in shared package mem_stage_pkg:
- state encoding;
- inMEM bit indices (MEM_READ=2, BRANCH=1, MEM_WRITE=0);
- TIMEOUT default.
REQ-036 SHALL implement the FSM, wait counter and read buffer in sub-module dmem_access_fsm; memory_access holds the MEM/WB register and branch logic.

Verification
REQ-037 SHALL verify pass-through: inMEM=000, inWB=10, inALUResult=0x1234, wreg=5 -> next edge outWB=10, outALUResult=0x1234, outRegF_wreg=5, outStall=0.
REQ-038 SHALL verify a load: inMEM=100, addr=0x40, ack after 3 cycles with rdata=0xDEADBEEF.
- outStall=1 until DONE.
- Bubbles during the stall.
- Then outReadData=0xDEADBEEF, outWB=inWB.
REQ-039 SHALL verify a store: inMEM=001, addr=0x10, inRegB=0xA5A5A5A5, immediate ack -> dmem_we=1, dmem_wdata=0xA5A5A5A5, single-cycle req, stall for 2 cycles.
REQ-040 SHALL verify a branch: inMEM=010, inALUZero=1, inPCJump=0x80 -> outPCSrc=1, outPCJump=0x80 same cycle; inALUZero=0 -> outPCSrc=0.
REQ-041 SHALL verify errors.
- Load at addr=0x42: no dmem_req, outMisalign=1, outWB=00.
- Load never acked: outTimeout=1 after 256 ACCESS cycles, outStall released.
REQ-042 SHALL verify reset mid-ACCESS: dmem_req drops immediately; a subsequent ack is ignored; outputs are at reset values.
